excess3_bcd_scheduler: RTL and testbench
========================================

Name: excess3_bcd_scheduler

Overview:
- Shares one excess-3→BCD digit-conversion datapath between two requesters.
- Each request is a packed multi-digit excess-3 word. The block grants requests round-robin and converts one digit per clock, least-significant digit first.
- It returns the packed BCD word, the requester ID and an illegal-code flag through a valid/ready output handshake.
- It sits between the code-conversion datapath and the blocks that produce and consume decimal words.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (≥1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  4*DIGITS  requester 0 excess-3 word; digit i is bits [4i+3:4i].
- req0_ready  output  1  requester 0 word is accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  4*DIGITS  requester 1 excess-3 word.
- req1_ready  output  1  requester 1 word is accepted this cycle.
- out_valid  output  1  result is available.
- out_data  output  4*DIGITS  packed BCD result, same digit ordering as the input.
- out_id  output  1  requester that owns the result.
- out_err  output  1  at least one digit was an illegal excess-3 code.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, prio=0, out_valid=0, out_data=0, out_id=0, out_err=0, digit count=0. req0_ready and req1_ready are 0 while rst=1.
- States: IDLE, CONV, DONE.
- IDLE arbitration:
  - Ready is combinational and asserted only in IDLE, only for the selected requester.
  - If only one requester is valid, it is selected.
  - If both are valid, the requester equal to prio is selected.
  - At most one ready is high per cycle.
  - Transfer occurs when valid and ready are both high. On that edge: capture data into the shift register, set out_id to the granted requester, clear out_err and the digit count, set prio to the other requester, and go to CONV.
- CONV, one digit per edge:
  - Take the low digit e of the shift register.
  - Legal codes are 0011–1100. For a legal code the output digit is e−3 (e.g. 1100→1001).
  - An illegal code (0000–0010 or 1101–1111) outputs digit 0000 and sets out_err, which is sticky for the word.
  - The converted digit is shifted into out_data from the MSD end; the shift register moves right by 4.
  - After DIGITS conversions, go to DONE and set out_valid=1.
- Latency: with the accept at edge E0, out_valid is high after edge E_DIGITS, i.e. DIGITS cycles after acceptance.
- out_data must not be sampled while out_valid=0 (it holds partial results during CONV).
- DONE:
  - out_valid, out_data, out_id and out_err are held stable while out_ready=0.
  - On out_valid and out_ready: clear out_valid and return to IDLE. No request is accepted in that same cycle.
  - The earliest next accept is the following cycle.
- Input hold: a requester holds valid and data until it sees ready. Deasserting valid before the grant is allowed and simply forfeits the slot.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Reset mid-operation: rst in CONV or DONE aborts the word. No out_valid is produced, the word is not re-requested internally, and prio returns to 0.
- Simultaneous events: rst has priority over all handshakes. A requester's valid rising in the same cycle another is granted waits for the next IDLE.

Test Plan (DIGITS=4):
- Single request: req0_data=16'h4C73 accepted → out_valid exactly 4 cycles later, out_data=16'h1940, out_id=0, out_err=0; busy high from the accept edge until the handshake.
- Contention: both valid after reset with words 16'h3456 and 16'hCBA9 → req0 granted first (result 16'h0123); then req1 (result 16'h9876, out_id=1); a third simultaneous pair grants req0 again.
- Illegal codes: req1_data=16'h5A21 → out_data=16'h2700, out_err=1, out_id=1; the next legal word reports out_err=0.
- Backpressure: out_ready held low 3 cycles in DONE → out_* stable and both readies 0 throughout; raising out_ready completes the transfer; the next accept occurs no earlier than one cycle later.
- Reset mid-CONV: assert rst on the 2nd conversion cycle → next cycle state IDLE, out_valid=0, out_data=0, prio=0; no stale result ever appears.
- Valid withdrawal: req1_valid pulsed for one cycle while busy → never granted and no output generated for it.

Source files
------------

// File: rtl/excess3_bcd_scheduler.sv
// Two-requester round-robin front end for a shared excess-3 to BCD digit converter.
// Converts one digit per clock, least-significant first, and returns the BCD word over valid/ready.
module excess3_bcd_scheduler #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [4*DIGITS-1:0]   req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [4*DIGITS-1:0]   req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_id,
  output logic                  out_err,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic            prio;
  logic [W-1:0]    shift_reg;
  logic [CW-1:0]   digit_cnt;
  logic            grant0;
  logic            grant1;
  logic [3:0]      e_digit;
  logic [3:0]      bcd_digit;
  logic            illegal;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !prio);
      grant1 = req1_valid && (!req0_valid ||  prio);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Legal excess-3 codes are 3..12; anything else converts to 0 and flags the word.
  assign e_digit   = shift_reg[3:0];
  assign illegal   = (e_digit < 4'd3) || (e_digit > 4'd12);
  assign bcd_digit = illegal ? 4'd0 : (e_digit - 4'd3);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      shift_reg <= '0;
      digit_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            shift_reg <= grant1 ? req1_data : req0_data;
            out_id    <= grant1;
            out_err   <= 1'b0;
            digit_cnt <= '0;
            prio      <= grant0;
            state     <= CONV;
          end
        end
        CONV: begin
          // Converted digits enter at the MSD end so the LSD lands in place after DIGITS shifts.
          out_data  <= (out_data >> 4) | (W'(bcd_digit) << (W - 4));
          shift_reg <= shift_reg >> 4;
          if (illegal) out_err <= 1'b1;
          if (digit_cnt == CW'(DIGITS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            digit_cnt <= digit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_excess3_bcd_scheduler.sv
// Directed bench for excess3_bcd_scheduler (DIGITS=4): arbitration, conversion,
// illegal codes, backpressure, mid-word reset and valid withdrawal.
module tb_excess3_bcd_scheduler;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         out_valid, out_id, out_err, out_ready, busy;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  excess3_bcd_scheduler #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for the result, checks it, optionally stalls, then completes the handshake.
  task automatic expect_result(input string tag, input logic [W-1:0] d, input logic id,
                               input logic err, input int lat, input int stall);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_data"}, out_data, d);
    check({tag, "_id"}, out_id, id);
    check({tag, "_err"}, out_err, err);
    check({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_stall_valid"}, out_valid, 1'b1);
      check({tag, "_stall_data"}, out_data, d);
      check({tag, "_stall_id_err"}, {out_id, out_err}, {id, err});
      check({tag, "_stall_ready"}, {req0_ready, req1_ready}, 2'b00);
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_hs_ready"}, {req0_ready, req1_ready}, 2'b00);
    step();
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, out_valid, 1'b0);
    check({tag, "_hs_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    step();
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_id_err", {out_id, out_err}, 2'b00);
    check("rst_busy", busy, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single request.
    req0_valid = 1'b1; req0_data = 16'h4C73;
    #1;
    check("single_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    check("single_busy", busy, 1'b1);
    expect_result("single", 16'h1940, 1'b0, 1'b0, 4, 0);

    // Contention from a fresh reset: req0, then req1, then req0 again.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h3456;
    req1_valid = 1'b1; req1_data = 16'hCBA9;
    #1;
    check("cont_grant0", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    check("cont_conv_ready", req1_ready, 1'b0);
    expect_result("cont0", 16'h0123, 1'b0, 1'b0, 4, 0);
    check("cont_grant1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_data = 16'h4C73;
    req0_valid = 1'b1; req0_data = 16'h3456;
    expect_result("cont1", 16'h9876, 1'b1, 1'b0, 4, 0);
    check("cont_grant2", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    expect_result("cont2", 16'h0123, 1'b0, 1'b0, 4, 0);

    // Illegal codes, then a legal word clears the flag.
    req1_valid = 1'b1; req1_data = 16'h5A21;
    #1;
    check("illegal_grant", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 1'b0;
    expect_result("illegal", 16'h2700, 1'b1, 1'b1, 4, 0);
    req0_valid = 1'b1; req0_data = 16'h4C73;
    step();
    req0_valid = 1'b0;
    expect_result("legal_after", 16'h1940, 1'b0, 1'b0, 4, 0);

    // Backpressure with req0 waiting throughout DONE.
    req1_valid = 1'b1; req1_data = 16'h3456;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 16'hCBA9;
    expect_result("bp", 16'h0123, 1'b1, 1'b0, 4, 3);
    check("bp_next_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    expect_result("bp_next", 16'h9876, 1'b0, 1'b0, 4, 0);

    // Reset during the second conversion cycle of a req0 word.
    req0_valid = 1'b1; req0_data = 16'h4C73;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_stale", {out_valid, busy}, 2'b00);
    end
    req0_valid = 1'b1; req0_data = 16'h3456;
    req1_valid = 1'b1; req1_data = 16'hCBA9;
    #1;
    check("midrst_prio", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    expect_result("post_rst", 16'h0123, 1'b0, 1'b0, 4, 0);

    // req1 pulses valid for one cycle while busy and must be forgotten.
    req0_valid = 1'b1; req0_data = 16'hCBA9;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_data = 16'h5A21;
    #1;
    check("withdraw_ready", req1_ready, 1'b0);
    step();
    req1_valid = 1'b0;
    expect_result("withdraw", 16'h9876, 1'b0, 1'b0, 2, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("withdraw_idle", {out_valid, busy, req1_ready}, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
